// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU request arbiter: op codes, FSM states and
// the default requester count.
package alu_arb_pkg;

    localparam int unsigned NREQ_DEFAULT = 4;

    localparam logic [2:0] OP_0    = 3'd0;
    localparam logic [2:0] OP_1    = 3'd1;
    localparam logic [2:0] OP_2    = 3'd2;
    localparam logic [2:0] OP_3    = 3'd3;
    localparam logic [2:0] OP_4    = 3'd4;
    localparam logic [2:0] OP_5    = 3'd5;
    localparam logic [2:0] OP_LAST = OP_5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Codes above OP_LAST select the mux default (zero) and are reported as errors.
    function automatic logic op_is_illegal(input logic [2:0] op);
        return (op > OP_LAST);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr wins,
// wrapping from NREQ-1 back to 0.
module rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEFAULT,
    parameter int unsigned IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx,
    output logic            gnt_valid
);

    // Scan NREQ candidates starting at ptr; the first asserted one is granted.
    always_comb begin
        int unsigned cand;
        logic [IW-1:0] cand_idx;
        gnt       = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            cand     = (32'(ptr) + off) % NREQ;
            cand_idx = IW'(cand);
            if (!gnt_valid && req[cand_idx]) begin
                gnt_valid     = 1'b1;
                gnt[cand_idx] = 1'b1;
                gnt_idx       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU and its result-select mux between NREQ requesters: accepts a
// single op via valid/ready, drives it to the ALU for one cycle, captures the
// result and returns it to the winner through a valid/ready response.
module alu_req_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEFAULT,
    parameter int unsigned WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [WIDTH-1:0]      alu_a,
    output logic [WIDTH-1:0]      alu_b,
    output logic [2:0]            alu_sel,
    input  logic [WIDTH-1:0]      alu_result,
    output logic [NREQ-1:0]       resp_valid,
    input  logic [NREQ-1:0]       resp_ready,
    output logic [WIDTH-1:0]      resp_data,
    output logic                  resp_err
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     gnt_idx_q, gnt_idx_d;
    logic [2:0]        alu_sel_q, alu_sel_d;
    logic [WIDTH-1:0]  alu_a_q, alu_a_d;
    logic [WIDTH-1:0]  alu_b_q, alu_b_d;
    logic [WIDTH-1:0]  resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [NREQ-1:0]   resp_valid_q, resp_valid_d;

    logic [NREQ-1:0]   arb_gnt;
    logic [IW-1:0]     arb_idx;
    logic              arb_valid;
    logic              accept;
    logic              resp_hs;
    int unsigned       op_base;
    int unsigned       dat_base;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_arbiter (
        .req       (req_valid),
        .ptr       (ptr_q),
        .gnt       (arb_gnt),
        .gnt_idx   (arb_idx),
        .gnt_valid (arb_valid)
    );

    // Ready is offered only in IDLE and is suppressed outright during reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && (state_q == ST_IDLE)) begin
            req_ready = arb_gnt;
        end
    end

    // Handshake qualifiers and slice offsets for the winning requester.
    always_comb begin
        accept   = (state_q == ST_IDLE) && arb_valid;
        resp_hs  = (state_q == ST_RESP) && resp_ready[gnt_idx_q];
        op_base  = 32'(arb_idx) * 3;
        dat_base = 32'(arb_idx) * WIDTH;
    end

    // Next-state and next-output computation for the IDLE/EXEC/RESP sequence.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_idx_d    = gnt_idx_q;
        alu_sel_d    = alu_sel_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        resp_valid_d = resp_valid_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    alu_sel_d = req_op[op_base +: 3];
                    alu_a_d   = req_a[dat_base +: WIDTH];
                    alu_b_d   = req_b[dat_base +: WIDTH];
                    gnt_idx_d = arb_idx;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                resp_err_d               = op_is_illegal(alu_sel_q);
                resp_data_d              = op_is_illegal(alu_sel_q) ? '0 : alu_result;
                resp_valid_d             = '0;
                resp_valid_d[gnt_idx_q]  = 1'b1;
                state_d                  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_hs) begin
                    resp_valid_d = '0;
                    ptr_d        = (gnt_idx_q == IW'(NREQ - 1)) ? '0 : gnt_idx_q + IW'(1);
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                resp_valid_d = '0;
                state_d      = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            gnt_idx_q    <= '0;
            alu_sel_q    <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            resp_valid_q <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_idx_q    <= gnt_idx_d;
            alu_sel_q    <= alu_sel_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    assign alu_sel    = alu_sel_q;
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign resp_valid = resp_valid_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench for alu_req_arbiter with a behavioural ALU on alu_result.
module tb_alu_req_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 16;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic [WIDTH-1:0]      alu_a;
    logic [WIDTH-1:0]      alu_b;
    logic [2:0]            alu_sel;
    logic [WIDTH-1:0]      alu_result;
    logic [NREQ-1:0]       resp_valid;
    logic [NREQ-1:0]       resp_ready;
    logic [WIDTH-1:0]      resp_data;
    logic                  resp_err;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] data;
        logic             err;
        int               acc_cyc;
        bit               seen;
    } exp_t;

    exp_t sb[$];
    int   acc_log[$];
    int   acc_cyc_log[$];

    alu_req_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_result (alu_result),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    // Reference ALU; codes 6/7 return garbage so the arbiter's zero forcing is visible.
    function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            3'd5:    return b;
            default: return 16'hDEAD;
        endcase
    endfunction

    assign alu_result = alu_f(alu_sel, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor: push on request handshake, pop and compare on response handshake.
    always @(negedge clk) begin : mon
        logic [NREQ-1:0] hs;
        logic [2:0]      op;
        logic [WIDTH-1:0] a, b;
        exp_t            e;
        int              idx;
        cyc++;
        if (!rst_n) begin
            chk("rst_req_ready", req_ready, '0);
            chk("rst_resp_valid", resp_valid, '0);
        end else begin
            hs = req_valid & req_ready;
            if (hs != '0) begin
                chk("ready_onehot", $countones(req_ready), 1);
                idx = 0;
                for (int i = 0; i < NREQ; i++) if (hs[i]) idx = i;
                op = req_op[3*idx +: 3];
                a  = req_a[WIDTH*idx +: WIDTH];
                b  = req_b[WIDTH*idx +: WIDTH];
                e.idx     = idx;
                e.err     = (op > 3'd5);
                e.data    = (op > 3'd5) ? '0 : alu_f(op, a, b);
                e.acc_cyc = cyc;
                e.seen    = 1'b0;
                sb.push_back(e);
                acc_log.push_back(idx);
                acc_cyc_log.push_back(cyc);
            end
            if (resp_valid != '0) begin
                if (sb.size() == 0) begin
                    chk("resp_spurious", resp_valid, '0);
                end else begin
                    if (!sb[0].seen) begin
                        chk("resp_latency", cyc - sb[0].acc_cyc, 2);
                        chk("resp_onehot", resp_valid, 32'(1) << sb[0].idx);
                        sb[0].seen = 1'b1;
                    end
                    if ((resp_valid & resp_ready) != '0) begin
                        e = sb.pop_front();
                        chk("resp_data", resp_data, e.data);
                        chk("resp_err", resp_err, e.err);
                    end
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [2:0] op,
                           input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        req_op[3*i +: 3]     = op;
        req_a[WIDTH*i +: WIDTH] = a;
        req_b[WIDTH*i +: WIDTH] = b;
    endtask

    // Raise valid on mask and wait for n accepts; drop=1 lowers each winner after its accept.
    task automatic serve(input logic [NREQ-1:0] mask, input int n, input bit drop);
        int got;
        logic [NREQ-1:0] hs;
        got = 0;
        @(posedge clk); #1;
        req_valid = req_valid | mask;
        for (int k = 0; k < 200 && got < n; k++) begin
            @(negedge clk);
            hs = req_valid & req_ready;
            if (hs != '0) begin
                got++;
                @(posedge clk); #1;
                if (drop) req_valid = req_valid & ~hs;
            end
        end
        if (got < n) chk("serve_timeout", got, n);
        req_valid = req_valid & ~mask;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge clk);
        @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    initial begin : main
        int start;
        rst_n      = 1'b0;
        req_valid  = '1;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '1;

        // Reset state, with every requester valid.
        repeat (3) @(negedge clk);
        chk("reset_alu_sel", alu_sel, 0);
        chk("reset_alu_a", alu_a, 0);
        chk("reset_alu_b", alu_b, 0);
        chk("reset_resp_data", resp_data, 0);
        chk("reset_resp_err", resp_err, 0);
        @(posedge clk); #1;
        req_valid = '0;
        rst_n     = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_ready", req_ready, '0);

        // Single request from requester 2: 0x1234 | 0x0001.
        set_req(2, 3'd3, 16'h1234, 16'h0001);
        @(posedge clk); #1;
        req_valid[2] = 1'b1;
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0100);
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        chk("single_alu_sel", alu_sel, 3);
        chk("single_alu_a", alu_a, 16'h1234);
        chk("single_alu_b", alu_b, 16'h0001);
        chk("single_exec_ready", req_ready, '0);
        @(negedge clk);
        chk("single_exec_no_valid", resp_valid, '0);
        @(negedge clk);
        chk("single_resp_valid", resp_valid, 4'b0100);
        chk("single_resp_data", resp_data, 16'h1235);
        chk("single_resp_err", resp_err, 0);
        wait_drain();

        // Wrap: ptr is 3, so requester 3 goes before requester 0.
        set_req(0, 3'd2, 16'h0FF0, 16'h00FF);
        set_req(3, 3'd4, 16'hAAAA, 16'h5555);
        start = acc_log.size();
        serve(4'b1001, 2, 1'b1);
        wait_drain();
        chk("wrap_count", acc_log.size(), start + 2);
        if (acc_log.size() >= start + 2) begin
            chk("wrap_first", acc_log[start], 3);
            chk("wrap_second", acc_log[start+1], 0);
        end

        // Reset pulse clears latched operands and the pointer.
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("pulse_alu_sel", alu_sel, 0);
        chk("pulse_alu_a", alu_a, 0);
        chk("pulse_resp_data", resp_data, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();

        // Round-robin with everyone continuously valid.
        set_req(0, 3'd1, 16'h0100, 16'h0003);
        set_req(1, 3'd0, 16'hFFFF, 16'h0002);
        set_req(2, 3'd5, 16'h1111, 16'hBEEF);
        set_req(3, 3'd4, 16'hF0F0, 16'h0FF0);
        start = acc_log.size();
        serve(4'b1111, 5, 1'b0);
        wait_drain();
        chk("rr_count", acc_log.size(), start + 5);
        if (acc_log.size() >= start + 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", acc_log[start+i], i % 4);
            for (int i = 1; i < 5; i++)
                chk("rr_spacing", acc_cyc_log[start+i] - acc_cyc_log[start+i-1], 3);
        end

        // Back-pressure on requester 1 while requester 0 waits.
        resp_ready = 4'b1101;
        set_req(1, 3'd1, 16'h0010, 16'h0003);
        serve(4'b0010, 1, 1'b1);
        set_req(0, 3'd5, 16'h0000, 16'h4321);
        req_valid[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_resp_valid", resp_valid, 4'b0010);
        chk("bp_resp_data", resp_data, 16'h000D);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_valid", resp_valid, 4'b0010);
            chk("bp_hold_data", resp_data, 16'h000D);
            chk("bp_no_ready", req_ready, '0);
        end
        @(posedge clk); #1;
        resp_ready = '1;
        start = acc_log.size();
        serve(4'b0001, 1, 1'b1);
        wait_drain();
        chk("bp_next_grant", (acc_log.size() > start) ? acc_log[start] : -1, 0);

        // Illegal op codes report an error with zero data.
        set_req(0, 3'd7, 16'hFFFF, 16'h0001);
        serve(4'b0001, 1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk("illegal_valid", resp_valid, 4'b0001);
        chk("illegal_err", resp_err, 1);
        chk("illegal_data", resp_data, 16'h0000);
        wait_drain();
        set_req(2, 3'd6, 16'h1234, 16'h5678);
        serve(4'b0100, 1, 1'b1);
        wait_drain();

        // Reset during EXEC discards the operation.
        set_req(2, 3'd0, 16'h7FFF, 16'h0001);
        serve(4'b0100, 1, 1'b1);
        set_req(3, 3'd2, 16'h00F0, 16'h0FF0);
        req_valid[3] = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_alu_a", alu_a, 0);
        chk("midrst_alu_b", alu_b, 0);
        chk("midrst_alu_sel", alu_sel, 0);
        chk("midrst_resp_valid", resp_valid, '0);
        chk("midrst_resp_data", resp_data, 0);
        chk("midrst_resp_err", resp_err, 0);
        chk("midrst_req_ready", req_ready, '0);
        sb.delete();
        req_valid = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("midrst_no_resp", resp_valid, '0);
        end
        start = acc_log.size();
        serve(4'b1000, 1, 1'b1);
        wait_drain();
        chk("midrst_next_grant", (acc_log.size() > start) ? acc_log[start] : -1, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
